// File: rtl/eq_band_scheduler.sv
// Sequencer for the 8-band equalizer: time-shares one pipelined MAC across all
// bands and taps of each audio sample, then shifts the z_block delay lines once.
module eq_band_scheduler #(
    parameter int BANDS   = 8,
    parameter int TAPS    = 3,
    parameter int MAC_LAT = 2,
    parameter int ADDR_W  = 5,
    localparam int BW = (BANDS > 1) ? $clog2(BANDS) : 1,
    localparam int TW = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic              overrun_clr,
    output logic              busy,
    output logic [BW-1:0]     band_idx,
    output logic [TW-1:0]     tap_idx,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              acc_latch,
    output logic              shift_en,
    output logic              frame_done,
    output logic              overrun,
    output logic [2:0]        dbg_state
);

    localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [BW-1:0] BAND_LAST = BW'(BANDS - 1);
    localparam logic [TW-1:0] TAP_LAST  = TW'(TAPS - 1);
    localparam logic [DW-1:0] DLY_LAST  = DW'(MAC_LAT - 1);

    if (BANDS * TAPS > (1 << ADDR_W)) begin : g_addr_check
        $fatal(1, "eq_band_scheduler: BANDS*TAPS does not fit in ADDR_W");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_LATCH = 3'd4,
        S_SHIFT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     band_q, band_d;
    logic [TW-1:0]     tap_q, tap_d;
    logic [DW-1:0]     dly_q, dly_d;
    logic              ovr_q, ovr_d;
    logic              busy_q, mac_clr_q, mac_en_q, acc_latch_q, shift_en_q, frame_done_q;
    logic [ADDR_W-1:0] coef_q, coef_d;

    // Handshake: sample_valid is a one-cycle strobe with no ready; it is taken
    // only in IDLE, otherwise it is dropped and recorded in the sticky overrun.
    always_comb begin
        state_d = state_q;
        band_d  = band_q;
        tap_d   = tap_q;
        dly_d   = dly_q;
        ovr_d   = ovr_q;
        if (overrun_clr)
            ovr_d = 1'b0;
        if (sample_valid && (state_q != S_IDLE))
            ovr_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                band_d = '0;
                tap_d  = '0;
                if (sample_valid)
                    state_d = S_CLEAR;
            end
            S_CLEAR: begin
                tap_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (tap_q == TAP_LAST) begin
                    dly_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    tap_d = tap_q + TW'(1);
                end
            end
            S_DRAIN: begin
                if (dly_q == DLY_LAST)
                    state_d = S_LATCH;
                else
                    dly_d = dly_q + DW'(1);
            end
            S_LATCH: begin
                if (band_q == BAND_LAST) begin
                    state_d = S_SHIFT;
                end else begin
                    band_d  = band_q + BW'(1);
                    tap_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_SHIFT: state_d = S_DONE;
            S_DONE: begin
                band_d  = '0;
                tap_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        coef_d = ADDR_W'(int'(band_d) * TAPS + int'(tap_d));
    end

    // Strobes are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            band_q       <= '0;
            tap_q        <= '0;
            dly_q        <= '0;
            ovr_q        <= 1'b0;
            coef_q       <= '0;
            busy_q       <= 1'b0;
            mac_clr_q    <= 1'b0;
            mac_en_q     <= 1'b0;
            acc_latch_q  <= 1'b0;
            shift_en_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            band_q       <= band_d;
            tap_q        <= tap_d;
            dly_q        <= dly_d;
            ovr_q        <= ovr_d;
            coef_q       <= coef_d;
            busy_q       <= (state_d != S_IDLE);
            mac_clr_q    <= (state_d == S_CLEAR);
            mac_en_q     <= (state_d == S_RUN);
            acc_latch_q  <= (state_d == S_LATCH);
            shift_en_q   <= (state_d == S_SHIFT);
            frame_done_q <= (state_d == S_DONE);
        end
    end

    assign busy       = busy_q;
    assign band_idx   = band_q;
    assign tap_idx    = tap_q;
    assign coef_addr  = coef_q;
    assign mac_clr    = mac_clr_q;
    assign mac_en     = mac_en_q;
    assign acc_latch  = acc_latch_q;
    assign shift_en   = shift_en_q;
    assign frame_done = frame_done_q;
    assign overrun    = ovr_q;
    assign dbg_state  = state_q;

endmodule
